// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and RAM-side signals of the unified memory port arbiter
interface mem_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              iREN;
  logic [DATA_W-1:0] iaddr;
  logic              iwait;
  logic [DATA_W-1:0] iload;
  logic              dREN;
  logic              dWEN;
  logic [DATA_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              dwait;
  logic [DATA_W-1:0] dload;
  logic [DATA_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic              ramREN;
  logic              ramWEN;
  logic [DATA_W-1:0] ramload;
  logic              ramready;
  logic              arb_err;
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
    output iwait, iload, dwait, dload, ramaddr, ramstore, ramREN, ramWEN, arb_err
  );
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
    input  iwait, iload, dwait, dload, ramaddr, ramstore, ramREN, ramWEN, arb_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between fetch and data with data priority, fetch anti-starvation and a watchdog
module mem_arbiter #(
  parameter int STREAK_MAX = 4,
  parameter int TIMEOUT    = 64,
  parameter int DATA_W     = 32
) (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;
  state_t            r_state, w_next;
  logic [3:0]        r_streak;
  logic [7:0]        r_wd;
  logic              r_err;
  logic              r_wr;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_store;
  logic              w_busy;
  logic              w_tmo;
  logic              w_done;
  logic              w_dreq;
  logic              w_force;
  logic              w_grant;
  logic [DATA_W-1:0] w_load;
  assign w_busy  = r_state != IDLE;
  assign w_tmo   = w_busy && !bus.ramready && r_wd == 8'(TIMEOUT - 1);
  assign w_done  = w_busy && (bus.ramready || w_tmo);
  assign w_dreq  = bus.dREN || bus.dWEN;
  assign w_force = bus.iREN && r_streak == 4'(STREAK_MAX);
  assign w_grant = r_state == IDLE && w_next != IDLE;
  assign w_load  = (bus.ramready && !r_wr) ? bus.ramload : '0;
  assign bus.ramREN   = w_busy && !r_wr;
  assign bus.ramWEN   = w_busy && r_wr;
  assign bus.ramaddr  = w_busy ? r_addr : '0;
  assign bus.ramstore = w_busy ? r_store : '0;
  assign bus.iwait    = !(r_state == IACC && w_done);
  assign bus.dwait    = !(r_state == DACC && w_done);
  assign bus.iload    = (r_state == IACC && w_done) ? w_load : '0;
  assign bus.dload    = (r_state == DACC && w_done) ? w_load : '0;
  assign bus.arb_err  = r_err || w_tmo;
  // next state: data first unless fetch has waited through a full streak; any completion or timeout returns to IDLE
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE)
      w_next = (w_dreq && !w_force) ? DACC : bus.iREN ? IACC : IDLE;
    else if (w_done)
      w_next = IDLE;
  end
  // state register and grant-time capture of address, write data and operation
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_store <= '0;
      r_wr    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_addr  <= w_next == DACC ? bus.daddr : bus.iaddr;
        r_store <= w_next == DACC ? bus.dstore : '0;
        r_wr    <= w_next == DACC && bus.dWEN;
      end
    end
  end
  // watchdog counts stalled access cycles; the error flag sticks until reset
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      r_wd <= (w_busy && !w_done) ? r_wd + 8'd1 : '0;
      if (w_tmo) r_err <= 1'b1;
    end
  end
  // streak counts data grants completed while fetch waits; a fetch completion clears it
  always_ff @(posedge CLK) begin
    if (!nRST)
      r_streak <= '0;
    else if (r_state == DACC && w_done)
      r_streak <= !bus.iREN ? '0 : r_streak == 4'(STREAK_MAX) ? r_streak : r_streak + 4'd1;
    else if (r_state == IACC && w_done)
      r_streak <= '0;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table plus directed sequences, completions checked against a scoreboard queue
module tb_mem_arbiter;
  typedef struct {
    logic        d;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] store;
    logic [31:0] load;
  } exp_t;
  typedef struct {
    logic        ir, dr, dw;
    logic [31:0] ia, da, ds, rl;
    int          dly;
    logic        ed;
    logic [31:0] ea;
    logic        ew;
    logic [31:0] es, el;
  } vec_t;
  logic clk = 1'b0;
  logic nrst;
  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];
  exp_t e;
  vec_t tbl[6];
  mem_arbiter_if #(.DATA_W(32)) bus();
  mem_arbiter #(.STREAK_MAX(4), .TIMEOUT(64), .DATA_W(32)) dut (.CLK(clk), .nRST(nrst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, a, x);
    end
  endtask
  function automatic exp_t mk(input logic d, input logic [31:0] addr, input logic wen, input logic [31:0] store, input logic [31:0] load);
    exp_t t;
    t.d = d; t.addr = addr; t.wen = wen; t.store = store; t.load = load;
    return t;
  endfunction
  // scoreboard: every completion pulse must match the oldest expected access
  always @(negedge clk) begin
    if (!bus.iwait || !bus.dwait) begin
      if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("owner", {30'd0, bus.iwait, bus.dwait}, e.d ? 32'd2 : 32'd1);
        chk("ramaddr", bus.ramaddr, e.addr);
        chk("ramWEN", {31'd0, bus.ramWEN}, {31'd0, e.wen});
        chk("ramREN", {31'd0, bus.ramREN}, {31'd0, !e.wen});
        if (e.wen) chk("ramstore", bus.ramstore, e.store);
        chk("load", e.d ? bus.dload : bus.iload, e.load);
      end
    end
  end
  task automatic serve(input int dly, input logic [31:0] rl);
    for (int k = 0; k <= dly; k++) begin
      #1 bus.ramready = (k == dly);
      bus.ramload = rl;
      @(posedge clk);
    end
    #1 bus.ramready = 1'b0;
  endtask
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    bus.iREN = v.ir; bus.dREN = v.dr; bus.dWEN = v.dw;
    bus.iaddr = v.ia; bus.daddr = v.da; bus.dstore = v.ds;
    exp_q.push_back(mk(v.ed, v.ea, v.ew, v.es, v.el));
    @(posedge clk);
    #1 bus.iaddr = ~v.ia; bus.daddr = ~v.da; bus.dstore = ~v.ds;
    serve(v.dly, v.rl);
    bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    @(negedge clk);
    chk("idle_after", {31'd0, bus.ramREN | bus.ramWEN}, 32'd0);
  endtask
  task automatic streak_seq();
    @(negedge clk);
    bus.iREN = 1'b1; bus.iaddr = 32'h300; bus.daddr = 32'h400; bus.dWEN = 1'b1; bus.dREN = 1'b0;
    for (int n = 0; n < 6; n++) begin
      bus.dstore = 32'hA000_0000 + n;
      if (n == 4) exp_q.push_back(mk(1'b0, 32'h300, 1'b0, 32'h0, 32'hFFFF_0004));
      else exp_q.push_back(mk(1'b1, 32'h400, 1'b1, 32'hA000_0000 + n, 32'h0));
      @(posedge clk);
      serve(0, 32'hFFFF_0000 + n);
    end
    bus.iREN = 1'b0; bus.dWEN = 1'b0;
  endtask
  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h4, 32'h0, 32'h0, 32'h2400_0001, 0, 1'b0, 32'h4, 1'b0, 32'h0, 32'h2400_0001};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 32'h0, 32'h0123_4567, 3, 1'b0, 32'h8, 1'b0, 32'h0, 32'h0123_4567};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h10, 32'h5, 32'hDEAD_BEEF, 1, 1'b1, 32'h10, 1'b0, 32'h0, 32'hDEAD_BEEF};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h14, 32'h1234_5678, 32'h9999_9999, 0, 1'b1, 32'h14, 1'b1, 32'h1234_5678, 32'h0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h200, 32'hCAFE_F00D, 32'h5555_AAAA, 2, 1'b1, 32'h200, 1'b1, 32'hCAFE_F00D, 32'h0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h8000_0001, 5, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h8000_0001};
    nrst = 1'b0;
    bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    bus.daddr = 32'h0; bus.dstore = 32'h0; bus.ramready = 1'b1; bus.ramload = 32'h0000_1234;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ramREN", {31'd0, bus.ramREN}, 32'd0);
    chk("rst_ramWEN", {31'd0, bus.ramWEN}, 32'd0);
    chk("rst_ramaddr", bus.ramaddr, 32'd0);
    chk("rst_ramstore", bus.ramstore, 32'd0);
    chk("rst_iwait", {31'd0, bus.iwait}, 32'd1);
    chk("rst_dwait", {31'd0, bus.dwait}, 32'd1);
    chk("rst_iload", bus.iload, 32'd0);
    chk("rst_dload", bus.dload, 32'd0);
    chk("rst_arb_err", {31'd0, bus.arb_err}, 32'd0);
    exp_q.push_back(mk(1'b0, 32'h40, 1'b0, 32'h0, 32'h0000_1234));
    nrst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 bus.iREN = 1'b0; bus.ramready = 1'b0;
    @(negedge clk);
    chk("first_idle_ren", {31'd0, bus.ramREN}, 32'd0);
    chk("first_idle_iwait", {31'd0, bus.iwait}, 32'd1);
    for (int i = 0; i < 6; i++) run_vec(tbl[i]);
    @(negedge clk);
    bus.ramready = 1'b1;
    @(posedge clk);
    #1 bus.ramready = 1'b0;
    @(negedge clk);
    chk("idle_ready_ren", {31'd0, bus.ramREN}, 32'd0);
    @(negedge clk);
    bus.iREN = 1'b1; bus.iaddr = 32'h80; bus.dREN = 1'b1; bus.daddr = 32'h100;
    exp_q.push_back(mk(1'b1, 32'h100, 1'b0, 32'h0, 32'h0000_D00D));
    exp_q.push_back(mk(1'b0, 32'h80, 1'b0, 32'h0, 32'h0000_1111));
    @(posedge clk);
    serve(2, 32'h0000_D00D);
    bus.dREN = 1'b0;
    @(posedge clk);
    serve(0, 32'h0000_1111);
    bus.iREN = 1'b0;
    streak_seq();
    @(negedge clk);
    bus.iREN = 1'b1; bus.iaddr = 32'h600;
    @(posedge clk);
    #1 bus.ramready = 1'b0;
    @(negedge clk);
    chk("iacc_ren", {31'd0, bus.ramREN}, 32'd1);
    chk("iacc_addr", bus.ramaddr, 32'h600);
    nrst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_ren", {31'd0, bus.ramREN}, 32'd0);
    chk("abort_iwait", {31'd0, bus.iwait}, 32'd1);
    chk("abort_addr", bus.ramaddr, 32'd0);
    bus.iREN = 1'b0;
    nrst = 1'b1;
    streak_seq();
    @(negedge clk);
    bus.dREN = 1'b1; bus.daddr = 32'h500; bus.ramload = 32'h77;
    exp_q.push_back(mk(1'b1, 32'h500, 1'b0, 32'h0, 32'h0));
    @(posedge clk);
    #1 bus.ramready = 1'b0;
    repeat (62) @(posedge clk);
    @(negedge clk);
    chk("wd63_dwait", {31'd0, bus.dwait}, 32'd1);
    chk("wd63_err", {31'd0, bus.arb_err}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("wd64_err", {31'd0, bus.arb_err}, 32'd1);
    @(posedge clk);
    #1 bus.dREN = 1'b0;
    @(negedge clk);
    chk("wd_idle_ren", {31'd0, bus.ramREN}, 32'd0);
    chk("wd_sticky", {31'd0, bus.arb_err}, 32'd1);
    run_vec(tbl[0]);
    chk("err_after_access", {31'd0, bus.arb_err}, 32'd1);
    @(negedge clk);
    nrst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("err_cleared", {31'd0, bus.arb_err}, 32'd0);
    nrst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
